// File: rtl/tdm_demux_1x8_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8_if
//   Bundles the serial input lane and the parallel frame outputs of the
//   8-channel TDM demultiplexer.
//
//   Serial side (driven by master):
//     din          W     channel word for the current slot
//     din_valid    1     beat qualifier
//     frame_sync   1     marks slot 0 (qualified by din_valid)
//   Frame side (driven by slave, the demux):
//     ch_data      8*W   published frame, channel k at [k*W +: W]
//     frame_valid  1     one-cycle pulse when ch_data updates
//     locked       1     frame alignment held
//     slot         3     slot the next accepted beat will fill
//     sync_err     1     one-cycle pulse on a sync violation
// ---------------------------------------------------------------------------
interface tdm_demux_1x8_if #(
    parameter int W = 1
);
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_sync;
    logic [8*W-1:0] ch_data;
    logic           frame_valid;
    logic           locked;
    logic [2:0]     slot;
    logic           sync_err;

    modport master (
        output din,
        output din_valid,
        output frame_sync,
        input  ch_data,
        input  frame_valid,
        input  locked,
        input  slot,
        input  sync_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  frame_sync,
        output ch_data,
        output frame_valid,
        output locked,
        output slot,
        output sync_err
    );
endinterface

// File: rtl/tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8
//   Receive-side 1:8 TDM demultiplexer. Locks onto frame_sync, collects one
//   channel word per accepted beat into shadow registers, and publishes the
//   complete 8-channel frame atomically on the 8th beat. Sync loss and early
//   sync are reported with a one-cycle sync_err pulse.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of tdm_demux_1x8_if (serial in, frame out)
// ---------------------------------------------------------------------------
module tdm_demux_1x8 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux_1x8_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q,       state_d;
    logic [2:0]     slot_q,        slot_d;
    logic           locked_q,      locked_d;
    logic           frame_valid_q, frame_valid_d;
    logic           sync_err_q,    sync_err_d;
    // Channels 0..6 of the frame under construction; channel 7 arrives with
    // the publishing beat and goes straight to ch_data.
    logic [7*W-1:0] shadow_q,      shadow_d;
    logic [8*W-1:0] ch_data_q,     ch_data_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        locked_d      = locked_q;
        shadow_d      = shadow_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (bus.din_valid) begin
            case (state_q)
                IDLE: begin
                    // Non-sync beats are silently ignored while hunting.
                    if (bus.frame_sync) begin
                        shadow_d[W-1:0] = bus.din;
                        slot_d          = 3'd1;
                        locked_d        = 1'b1;
                        state_d         = RUN;
                    end
                end
                RUN: begin
                    if (bus.frame_sync) begin
                        // Sync always restarts the frame; anywhere other
                        // than slot 0 it drops the partial frame, even at
                        // slot 7 where a publish would otherwise happen.
                        sync_err_d      = (slot_q != 3'd0);
                        shadow_d[W-1:0] = bus.din;
                        slot_d          = 3'd1;
                    end else if (slot_q == 3'd0) begin
                        // Expected a sync marker: alignment lost.
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        slot_d     = 3'd0;
                        state_d    = IDLE;
                    end else if (slot_q == 3'd7) begin
                        ch_data_d     = {bus.din, shadow_q};
                        frame_valid_d = 1'b1;
                        slot_d        = 3'd0;
                    end else begin
                        for (int k = 1; k < 7; k++) begin
                            if (slot_q == 3'(k)) begin
                                shadow_d[k*W +: W] = bus.din;
                            end
                        end
                        slot_d = slot_q + 3'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    slot_d   = 3'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= 3'd0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            shadow_q      <= '0;
            ch_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            locked_q      <= locked_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            shadow_q      <= shadow_d;
            ch_data_q     <= ch_data_d;
        end
    end

    assign bus.ch_data     = ch_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.slot        = slot_q;
    assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x8
//   Scoreboard bench for tdm_demux_1x8 with W=4. The driver applies beats and
//   advances a frame-level reference model; expected frame_valid / sync_err
//   events are queued with the cycle they must appear in. A negedge monitor
//   pops and compares events and checks locked/slot/ch_data every cycle.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x8;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux_1x8_if #(.W(W)) bus ();

    tdm_demux_1x8 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        bit          is_fv;
        logic [31:0] data;
    } ev_t;

    ev_t         evq[$];
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;
    int          last_fv = 0;
    int          prev_fv = 0;
    int          serr_cnt = 0;

    // Reference model: frame-level view of the receiver.
    bit          m_locked;
    int          m_slot;
    logic [3:0]  m_frame [8];
    logic [31:0] m_pub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_slot   = 0;
        m_pub    = '0;
        for (int k = 0; k < 8; k++) m_frame[k] = '0;
        evq.delete();
    endtask

    task automatic push_ev(input bit is_fv, input logic [31:0] data);
        ev_t e;
        e.cyc   = ncyc + 1;
        e.is_fv = is_fv;
        e.data  = data;
        evq.push_back(e);
    endtask

    task automatic model_beat(input logic [3:0] d, input bit sync);
        if (!m_locked) begin
            if (sync) begin
                m_frame[0] = d;
                m_slot     = 1;
                m_locked   = 1'b1;
            end
        end else if (sync) begin
            if (m_slot != 0) push_ev(1'b0, '0);
            m_frame[0] = d;
            m_slot     = 1;
        end else if (m_slot == 0) begin
            push_ev(1'b0, '0);
            m_locked = 1'b0;
        end else begin
            m_frame[m_slot] = d;
            if (m_slot == 7) begin
                for (int k = 0; k < 8; k++) m_pub[k*4 +: 4] = m_frame[k];
                push_ev(1'b1, m_pub);
                m_slot = 0;
            end else begin
                m_slot = m_slot + 1;
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge with din_valid=0.
    task automatic beat(input logic [3:0] d, input bit sync, input int gap);
        repeat (gap) @(negedge clk);
        bus.din        = d;
        bus.frame_sync = sync;
        bus.din_valid  = 1'b1;
        @(posedge clk);
        model_beat(d, sync);
        @(negedge clk);
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    task automatic good_frame(input int base, input int maxgap);
        for (int k = 0; k < 8; k++)
            beat(4'((base + k) & 15), k == 0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_ch_data"},  bus.ch_data, 32'h0);
        chk({tag, "_fvalid"},   32'(bus.frame_valid), 32'h0);
        chk({tag, "_locked"},   32'(bus.locked), 32'h0);
        chk({tag, "_slot"},     32'(bus.slot), 32'h0);
        chk({tag, "_sync_err"}, 32'(bus.sync_err), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor
    always @(negedge clk) begin
        ncyc++;
        if (rst_n) begin
            while (evq.size() > 0 && evq[0].cyc < ncyc) begin
                total++;
                bad++;
                $display("FAIL missing_event: got=none expected=%s at cycle %0d",
                         evq[0].is_fv ? "frame_valid" : "sync_err", evq[0].cyc);
                void'(evq.pop_front());
            end
            if (bus.frame_valid && bus.sync_err) begin
                total++;
                bad++;
                $display("FAIL pulse_overlap: got=both expected=at most one (cycle %0d)", ncyc);
            end
            if (bus.frame_valid) begin
                prev_fv = last_fv;
                last_fv = ncyc;
            end
            if (bus.sync_err) serr_cnt++;
            if (bus.frame_valid || bus.sync_err) begin
                if (evq.size() == 0 || evq[0].cyc != ncyc) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got fv=%0b serr=%0b expected=none (cycle %0d)",
                             bus.frame_valid, bus.sync_err, ncyc);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("event_kind", 32'(bus.frame_valid), 32'(e.is_fv));
                    if (e.is_fv) chk("frame_data", bus.ch_data, e.data);
                end
            end
            chk("locked", 32'(bus.locked), 32'(m_locked));
            chk("slot",   32'(bus.slot),   32'(m_slot));
            chk("ch_data_hold", bus.ch_data, m_pub);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit sync;
        rst_n          = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();
        #1;
        chk("reset_ch_data", bus.ch_data, 32'h0);
        chk("reset_locked",  32'(bus.locked), 32'h0);
        chk("reset_slot",    32'(bus.slot), 32'h0);
        chk("reset_fvalid",  32'(bus.frame_valid), 32'h0);
        chk("reset_serr",    32'(bus.sync_err), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain frame, din = slot index
        good_frame(0, 0);
        #1;
        chk("t1_ch_data", bus.ch_data, 32'h76543210);

        // 2: same frame with random gaps
        good_frame(0, 5);
        #1;
        chk("t2_ch_data", bus.ch_data, 32'h76543210);

        // 3: sync re-asserted on beat 4
        for (int k = 0; k < 4; k++) beat(4'(k + 8), k == 0, 0);
        beat(4'hA, 1'b1, 0);
        #1;
        chk("t3_locked", 32'(bus.locked), 32'h1);
        chk("t3_slot",   32'(bus.slot), 32'h1);
        for (int k = 1; k < 8; k++) beat(4'(k + 2), 1'b0, 0);
        #1;
        chk("t3_ch_data", bus.ch_data, 32'h9876543A);

        // 4: slot-0 beat without sync after a good frame
        good_frame(5, 0);
        beat(4'h3, 1'b0, 0);
        #1;
        chk("t4_locked", 32'(bus.locked), 32'h0);
        chk("t4_slot",   32'(bus.slot), 32'h0);
        for (int k = 0; k < 4; k++) beat(4'(k), 1'b0, 1);
        good_frame(9, 1);

        // 5: async reset mid-frame
        for (int k = 0; k < 5; k++) beat(4'(k + 1), k == 0, 0);
        async_reset_check("t5");
        @(negedge clk);
        good_frame(3, 2);
        #1;
        chk("t5_ch_data", bus.ch_data, 32'hA9876543);

        // 6: back-to-back frames with continuous valid
        s0 = serr_cnt;
        good_frame(1, 0);
        good_frame(7, 0);
        #1;
        chk("t6_spacing", 32'(last_fv - prev_fv), 32'd8);
        chk("t6_no_serr", 32'(serr_cnt - s0), 32'd0);

        // Randomized traffic with occasional sync faults
        for (int i = 0; i < 500; i++) begin
            sync = m_locked ? (m_slot == 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) sync = ~sync;
            beat(4'($urandom), sync, ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", 32'(evq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
